// File: rtl/snap_irq_pkg.sv
// snap_irq_pkg
// Shared types and constants for the SNAP interrupt requester:
//   - irq_state_e     : requester FSM states
//   - DEF_*_WIDTH     : default field widths
//   - timer_width()   : bit width of the shared down counter
package snap_irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_REQ        = 2'd1,
        ST_WAIT_CLEAR = 2'd2,
        ST_HOLDOFF    = 2'd3
    } irq_state_e;

    localparam int DEF_SRC_WIDTH = 64;
    localparam int DEF_CTX_WIDTH = 9;
    localparam int DEF_CNT_WIDTH = 16;

    // Counter must hold the larger of the two load values; never narrower than 1 bit.
    function automatic int timer_width(input int timeout_cycles, input int holdoff_cycles);
        int max_cycles;
        max_cycles = (timeout_cycles > holdoff_cycles) ? timeout_cycles : holdoff_cycles;
        return (max_cycles < 1) ? 1 : $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/snap_irq_requester_timer.sv
// irq_cycle_timer
// Loadable down counter shared by the request timeout and the re-arm holdoff.
// The count stops at zero, so a zero load never produces an expiry.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_i       : load load_val_i (takes priority over decrement)
//   load_val_i   : value to load
//   dec_i        : decrement this cycle
//   expire_o     : count is 1 while decrementing (reaches zero at this edge)
module irq_cycle_timer #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             expire_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: load wins, otherwise decrement and stop at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = dec_i && (count_q == ONE);

endmodule

// File: rtl/snap_irq_requester.sv
// snap_irq_requester
// Turns the global register slave's level interrupt into the SNAP host
// request/acknowledge handshake. One request outstanding at a time; after an
// ack the level must be cleared by software, then a holdoff elapses before
// re-arming. A request without ack within TIMEOUT_CYCLES is dropped, flagged
// in o_timeout_err, and retried after the holdoff.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   i_irq_level, i_enable      : level interrupt, request permit
//   i_irq_src, i_irq_ctx       : source/context, sampled at request launch
//   o_interrupt                : host request, held until ack or timeout
//   o_interrupt_src/_ctx       : latched source/context
//   i_interrupt_ack            : host acknowledge pulse
//   o_irq_count                : acknowledged requests, saturating
//   o_timeout_err, i_err_clear : sticky timeout flag and its clear
module snap_irq_requester
    import snap_irq_pkg::*;
#(
    parameter int SRC_WIDTH      = DEF_SRC_WIDTH,
    parameter int CTX_WIDTH      = DEF_CTX_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int HOLDOFF_CYCLES = 16,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_irq_level,
    input  logic                 i_enable,
    input  logic [SRC_WIDTH-1:0] i_irq_src,
    input  logic [CTX_WIDTH-1:0] i_irq_ctx,
    output logic                 o_interrupt,
    output logic [SRC_WIDTH-1:0] o_interrupt_src,
    output logic [CTX_WIDTH-1:0] o_interrupt_ctx,
    input  logic                 i_interrupt_ack,
    output logic [CNT_WIDTH-1:0] o_irq_count,
    output logic                 o_timeout_err,
    input  logic                 i_err_clear
);

    localparam int                 TIMER_W     = timer_width(TIMEOUT_CYCLES, HOLDOFF_CYCLES);
    localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] HOLDOFF_VAL = TIMER_W'(HOLDOFF_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    irq_state_e           state_q, state_d;
    logic                 interrupt_q, interrupt_d;
    logic [SRC_WIDTH-1:0] src_q, src_d;
    logic [CTX_WIDTH-1:0] ctx_q, ctx_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic                 tmr_load_s;
    logic [TIMER_W-1:0]   tmr_val_s;
    logic                 tmr_dec_s;
    logic                 tmr_expire_s;

    irq_cycle_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .dec_i      (tmr_dec_s),
        .expire_o   (tmr_expire_s)
    );

    // Next-state, output and timer control logic.
    always_comb begin
        state_d     = state_q;
        interrupt_d = interrupt_q;
        src_d       = src_q;
        ctx_d       = ctx_q;
        cnt_d       = cnt_q;
        tmr_load_s  = 1'b0;
        tmr_val_s   = '0;
        tmr_dec_s   = 1'b0;
        // Clear first so that a set in the same cycle below overrides it.
        if (i_err_clear) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_irq_level && i_enable) begin
                    state_d     = ST_REQ;
                    interrupt_d = 1'b1;
                    src_d       = i_irq_src;
                    ctx_d       = i_irq_ctx;
                    tmr_load_s  = 1'b1;
                    tmr_val_s   = TIMEOUT_VAL;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_REQ: begin
                tmr_dec_s = 1'b1;
                // Ack is checked before expiry: a same-cycle ack is a success.
                if (i_interrupt_ack && interrupt_q) begin
                    state_d     = ST_WAIT_CLEAR;
                    interrupt_d = 1'b0;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else if (tmr_expire_s) begin
                    state_d     = ST_HOLDOFF;
                    interrupt_d = 1'b0;
                    err_d       = 1'b1;
                    tmr_load_s  = 1'b1;
                    tmr_val_s   = HOLDOFF_VAL;
                end else begin
                    state_d = ST_REQ;
                end
            end

            ST_WAIT_CLEAR: begin
                if (!i_irq_level) begin
                    state_d    = ST_HOLDOFF;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = HOLDOFF_VAL;
                end else begin
                    state_d = ST_WAIT_CLEAR;
                end
            end

            ST_HOLDOFF: begin
                tmr_dec_s = 1'b1;
                if (tmr_expire_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLDOFF;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                interrupt_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            interrupt_q <= 1'b0;
            src_q       <= '0;
            ctx_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            interrupt_q <= interrupt_d;
            src_q       <= src_d;
            ctx_q       <= ctx_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign o_interrupt     = interrupt_q;
    assign o_interrupt_src = src_q;
    assign o_interrupt_ctx = ctx_q;
    assign o_irq_count     = cnt_q;
    assign o_timeout_err   = err_q;

endmodule

// File: tb/tb_snap_irq_requester.sv
// Bench for snap_irq_requester: directed table, hand-written corner
// sequences and randomized traffic, all compared against a request-level
// reference model that tracks request age and remaining holdoff.
module tb_snap_irq_requester;

    localparam int SW      = 64;
    localparam int CW      = 9;
    localparam int TO      = 8;
    localparam int HO      = 16;
    localparam int NW      = 4;
    localparam int CNT_MAX = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          lvl = 1'b0, en = 1'b0, ack = 1'b0, clr = 1'b0;
    logic [SW-1:0] src = '0;
    logic [CW-1:0] ctx = '0;
    logic          o_int;
    logic [SW-1:0] o_src;
    logic [CW-1:0] o_ctx;
    logic [NW-1:0] o_cnt;
    logic          o_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: outstanding request flag, its age, awaiting-clear flag,
    // remaining holdoff cycles, plus the visible latched values.
    bit            m_int, m_wait_clear, m_err;
    logic [SW-1:0] m_src;
    logic [CW-1:0] m_ctx;
    int            m_cnt, m_age, m_hold;

    snap_irq_requester #(
        .SRC_WIDTH(SW), .CTX_WIDTH(CW), .TIMEOUT_CYCLES(TO),
        .HOLDOFF_CYCLES(HO), .CNT_WIDTH(NW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_irq_level(lvl), .i_enable(en),
        .i_irq_src(src), .i_irq_ctx(ctx), .o_interrupt(o_int),
        .o_interrupt_src(o_src), .o_interrupt_ctx(o_ctx),
        .i_interrupt_ack(ack), .o_irq_count(o_cnt),
        .o_timeout_err(o_err), .i_err_clear(clr)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Overall time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_int = 1'b0; m_wait_clear = 1'b0; m_err = 1'b0;
        m_src = '0; m_ctx = '0; m_cnt = 0; m_age = 0; m_hold = 0;
    endtask

    task automatic model_step();
        if (clr) m_err = 1'b0;
        if (m_int) begin
            m_age++;
            if (ack) begin
                m_int = 1'b0;
                if (m_cnt < CNT_MAX) m_cnt++;
                m_wait_clear = 1'b1;
            end else if (TO != 0 && m_age == TO) begin
                m_int  = 1'b0;
                m_err  = 1'b1;
                m_hold = HO;
            end
        end else if (m_wait_clear) begin
            if (!lvl) begin
                m_wait_clear = 1'b0;
                m_hold = HO;
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (lvl && en) begin
            m_int = 1'b1;
            m_src = src;
            m_ctx = ctx;
            m_age = 0;
        end
    endtask

    task automatic compare_model();
        check("mdl_int", 64'(o_int), 64'(m_int));
        check("mdl_src", o_src, m_src);
        check("mdl_ctx", 64'(o_ctx), 64'(m_ctx));
        check("mdl_cnt", 64'(o_cnt), 64'(m_cnt));
        check("mdl_err", 64'(o_err), 64'(m_err));
    endtask

    // One clock: model follows the same edge, outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        compare_model();
    endtask

    // n holdoff cycles with no request, then the launching edge.
    task automatic holdoff_launch(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            check({name, "_hold"}, 64'(o_int), 64'd0);
        end
        tick();
        check({name, "_launch"}, 64'(o_int), 64'd1);
    endtask

    typedef struct {
        logic          lvl, en, ack, clr;
        logic [SW-1:0] src;
        logic [CW-1:0] ctx;
        logic          exp_int;
        logic [SW-1:0] exp_src;
        logic [CW-1:0] exp_ctx;
        int            exp_cnt;
        logic          exp_err;
    } vec_t;

    function automatic vec_t mk(input logic l, input logic e, input logic a, input logic c,
                                input logic [SW-1:0] s, input logic [CW-1:0] x,
                                input logic ei, input logic [SW-1:0] es,
                                input logic [CW-1:0] ex, input int ec, input logic ee);
        vec_t v;
        v.lvl = l; v.en = e; v.ack = a; v.clr = c; v.src = s; v.ctx = x;
        v.exp_int = ei; v.exp_src = es; v.exp_ctx = ex; v.exp_cnt = ec; v.exp_err = ee;
        return v;
    endfunction

    vec_t vecs[11];

    initial begin
        logic [SW-1:0] to_src;
        //               lvl   en    ack   clr   src            ctx     int   esrc   ectx    cnt err
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 64'h1,         9'h005, 1'b0, 64'h0, 9'h000, 0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 64'h1,         9'h005, 1'b0, 64'h0, 9'h000, 0, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 64'h1,         9'h005, 1'b0, 64'h0, 9'h000, 0, 1'b0);
        vecs[3]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 64'h1,         9'h005, 1'b1, 64'h1, 9'h005, 0, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 64'hDEAD_BEEF, 9'h1FF, 1'b1, 64'h1, 9'h005, 0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'hDEAD_BEEF, 9'h1FF, 1'b1, 64'h1, 9'h005, 0, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 64'h1,         9'h005, 1'b0, 64'h1, 9'h005, 1, 1'b0);
        vecs[7]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 64'h1,         9'h005, 1'b0, 64'h1, 9'h005, 1, 1'b0);
        vecs[8]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 64'h1,         9'h005, 1'b0, 64'h1, 9'h005, 1, 1'b0);
        vecs[9]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 64'h1,         9'h005, 1'b0, 64'h1, 9'h005, 1, 1'b0);
        vecs[10] = mk(1'b1, 1'b1, 1'b0, 1'b0, 64'h2,         9'h003, 1'b0, 64'h1, 9'h005, 1, 1'b0);

        // Reset state.
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_int", 64'(o_int), 64'd0);
        check("rst_src", o_src, 64'd0);
        check("rst_ctx", 64'(o_ctx), 64'd0);
        check("rst_cnt", 64'(o_cnt), 64'd0);
        check("rst_err", 64'(o_err), 64'd0);
        #3 rst_n = 1'b1;

        // Table: gating, launch, stability, ack, ignored acks, clear.
        for (int i = 0; i < 11; i++) begin
            lvl = vecs[i].lvl; en = vecs[i].en; ack = vecs[i].ack; clr = vecs[i].clr;
            src = vecs[i].src; ctx = vecs[i].ctx;
            tick();
            check($sformatf("vec%0d_int", i), 64'(o_int), 64'(vecs[i].exp_int));
            check($sformatf("vec%0d_src", i), o_src, vecs[i].exp_src);
            check($sformatf("vec%0d_ctx", i), 64'(o_ctx), 64'(vecs[i].exp_ctx));
            check($sformatf("vec%0d_cnt", i), 64'(o_cnt), 64'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_err", i), 64'(o_err), 64'(vecs[i].exp_err));
        end
        ack = 1'b0; clr = 1'b0;

        // Re-arm: one holdoff cycle already elapsed in the table.
        holdoff_launch("rearm", 15);
        check("rearm_src", o_src, 64'h2);
        check("rearm_ctx", 64'(o_ctx), 64'h3);
        ack = 1'b1; tick(); ack = 1'b0;
        check("rearm_cnt", 64'(o_cnt), 64'd2);

        // Timeout without ack.
        lvl = 1'b0; tick(); lvl = 1'b1;
        to_src = {$urandom, $urandom}; src = to_src; ctx = 9'h0A5;
        holdoff_launch("to", 16);
        check("to_src", o_src, to_src);
        for (int k = 0; k < 7; k++) begin
            tick();
            check("to_held", 64'(o_int), 64'd1);
        end
        tick();
        check("to_drop", 64'(o_int), 64'd0);
        check("to_err_set", 64'(o_err), 64'd1);
        clr = 1'b1; tick(); clr = 1'b0;
        check("to_err_clear", 64'(o_err), 64'd0);

        // Retry, acknowledged exactly on the expiry cycle.
        holdoff_launch("retry", 15);
        for (int k = 0; k < 7; k++) begin
            tick();
            check("retry_held", 64'(o_int), 64'd1);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        check("coll_int", 64'(o_int), 64'd0);
        check("coll_err", 64'(o_err), 64'd0);
        check("coll_cnt", 64'(o_cnt), 64'd3);

        // Timeout with clear asserted on the expiry edge: set wins.
        lvl = 1'b0; tick(); lvl = 1'b1;
        holdoff_launch("sw", 16);
        repeat (7) tick();
        clr = 1'b1; tick(); clr = 1'b0;
        check("setwins_err", 64'(o_err), 64'd1);
        clr = 1'b1; tick(); clr = 1'b0;
        check("setwins_clear", 64'(o_err), 64'd0);
        holdoff_launch("pre_rst", 15);

        // Asynchronous reset while requesting.
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_int", 64'(o_int), 64'd0);
        check("arst_cnt", 64'(o_cnt), 64'd0);
        compare_model();
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("post_rst_launch", 64'(o_int), 64'd1);

        // Counter saturation.
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            ack = 1'b1; tick(); ack = 1'b0;
            check("sat_cnt", 64'(o_cnt), 64'((i + 1 < CNT_MAX) ? i + 1 : CNT_MAX));
            lvl = 1'b0; tick(); lvl = 1'b1;
            holdoff_launch("sat", 16);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            lvl = ($urandom_range(0, 99) < 70);
            en  = ($urandom_range(0, 99) < 80);
            ack = ($urandom_range(0, 99) < 15);
            clr = ($urandom_range(0, 99) < 5);
            src = {$urandom, $urandom};
            ctx = CW'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
